// File: rtl/btn_conditioner_pkg.sv
// rtl/btn_conditioner_pkg.sv - shared button indices and debounce defaults
package btn_conditioner_pkg;

    localparam int BTN_UP1   = 0;
    localparam int BTN_DOWN1 = 1;
    localparam int BTN_UP2   = 2;
    localparam int BTN_DOWN2 = 3;
    localparam int BTN_ENTER = 4;

    // 10 ms at 100 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 1000000;
    localparam int CNT_W_DEF           = 20;

endpackage

// File: rtl/btn_conditioner_debounce_bit.sv
// rtl/btn_conditioner_debounce_bit.sv - synchronizer, debounce counter and rise pulse for one button
module debounce_bit
    import btn_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;
    logic             level_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_raw;
            sync_2 <= sync_1;
        end
    end

    // Counter only runs while the input disagrees with the stable level and clears at the threshold, so it cannot wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt       <= '0;
            btn_level <= 1'b0;
        end else if (sync_2 == btn_level) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt       <= '0;
            btn_level <= ~btn_level;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            level_d   <= 1'b0;
            btn_pulse <= 1'b0;
        end else begin
            level_d   <= btn_level;
            btn_pulse <= btn_level & ~level_d;
        end
    end

endmodule

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - debounced levels and press pulses for the game push-buttons
module btn_conditioner
    import btn_conditioner_pkg::*;
#(
    parameter int N_BTN           = 5,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_BTN-1:0] btn_raw,
    output logic [N_BTN-1:0] btn_level,
    output logic [N_BTN-1:0] btn_pulse,
    output logic             up1_p,
    output logic             down1_p,
    output logic             enter_p
);

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clk      (clk),
            .reset    (reset),
            .btn_raw  (btn_raw[i]),
            .btn_level(btn_level[i]),
            .btn_pulse(btn_pulse[i])
        );
    end

    // Menu inputs tap the registered pulses directly.
    assign up1_p   = btn_pulse[BTN_UP1];
    assign down1_p = btn_pulse[BTN_DOWN1];
    assign enter_p = btn_pulse[BTN_ENTER];

endmodule

// File: doc/btn_conditioner.md
BTN_CONDITIONER -- requirements
Module: btn_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 5: number of push-buttons conditioned.
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stable-input cycles required before the debounced level changes (10 ms at 100 MHz).
REQ-003 SHALL have parameter CNT_W, default 20: counter width, sized to hold DEBOUNCE_CYCLES-1.
REQ-004 SHALL have port clk, input, 1 bit: system clock, all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port btn_raw, input, N_BTN bits: raw asynchronous buttons; bit0 up1, bit1 down1, bit2 up2, bit3 down2, bit4 enter.
REQ-007 SHALL have port btn_level, output, N_BTN bits: debounced level per button, for paddle motion.
REQ-008 SHALL have port btn_pulse, output, N_BTN bits: one-cycle pulse on each debounced 0->1 transition.
REQ-009 SHALL have ports up1_p, down1_p, enter_p, outputs, 1 bit each: aliases of btn_pulse[0], [1] and [4], feeding the start-menu up1/down1/enter inputs.

Function
REQ-010 SHALL pass each btn_raw bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep, per button, a counter and a stable-level register; all buttons are independent.
- Synchronized input equals the stable level: counter cleared to 0.
- Synchronized input differs: counter increments by 1 per cycle.
- Counter reaches DEBOUNCE_CYCLES-1 while the input still differs: stable level toggles on the next edge and the counter clears.
REQ-012 SHALL clear the counter to 0 on any cycle where the input returns to the stable level before the threshold. A glitch shorter than DEBOUNCE_CYCLES never changes btn_level.
REQ-013 SHALL assert btn_pulse[i] for exactly one clk cycle, on the cycle after btn_level[i] rises 0->1. It SHALL NOT pulse on a 1->0 transition.
REQ-014 SHALL assert no further btn_pulse[i] while btn_level[i] stays high, however long the button is held.
REQ-015 SHALL make the latency from a clean raw edge to the btn_level change equal to 2 (synchronizer) + DEBOUNCE_CYCLES cycles, +1 more for btn_pulse.
REQ-016 SHALL let several buttons change on the same cycle and produce their pulses on the same cycle; there is no priority or arbitration.
REQ-017 SHALL saturate-safely: the counter never exceeds DEBOUNCE_CYCLES-1 and never wraps.
REQ-018 SHALL drive all outputs from registers; no combinational path from btn_raw to any output.

Reset
REQ-019 SHALL, while reset is high, asynchronously force all of the following to 0:
- synchronizer flops, counters and stable levels;
- btn_level and btn_pulse, and therefore up1_p, down1_p and enter_p.
REQ-020 SHALL treat a button held high through reset release as a new press: after 2+DEBOUNCE_CYCLES cycles btn_level rises and exactly one pulse is produced.
REQ-021 SHALL abandon any in-progress count when reset is asserted mid-debounce, with no pulse produced.

Structure
REQ-022 SHALL place the button index constants (BTN_UP1=0, BTN_DOWN1=1, BTN_UP2=2, BTN_DOWN2=3, BTN_ENTER=4) and the default DEBOUNCE_CYCLES in the shared game package.
REQ-023 SHALL implement one sub-module, debounce_bit (synchronizer, counter, stable level and edge pulse for a single button), instantiated N_BTN times in a generate loop.

Verification (DEBOUNCE_CYCLES=8, CNT_W=4)
REQ-024 SHALL cover a clean press: btn_raw[4] 0->1 held 20 cycles -> btn_level[4] rises 10 cycles after the edge, enter_p high for exactly 1 cycle, one cycle later.
REQ-025 SHALL cover glitch rejection: btn_raw[0] high for 5 cycles then low -> btn_level[0] and up1_p stay 0 throughout.
REQ-026 SHALL cover a long hold: btn_raw[1] held high 100 cycles -> exactly one down1_p pulse; release -> btn_level[1] falls 10 cycles later with no pulse.
REQ-027 SHALL cover simultaneous presses: btn_raw=5'b00011 on the same edge -> up1_p and down1_p pulse on the same cycle.
REQ-028 SHALL cover reset mid-count: press btn_raw[4], assert reset on cycle 6 for 2 cycles while still held -> outputs 0 during reset, then exactly one enter_p pulse 11 cycles after reset release.
REQ-029 SHALL cover a chattering input: btn_raw[2] toggling every 3 cycles for 30 cycles, then steady high -> a single pulse, only after 10 cycles of steady high.
